// File: rtl/apb_hetic_pkg.sv
// Shared types and constants for the hetic interrupt controller.
package apb_hetic_pkg;

  localparam int unsigned HeticWindowBytes = 4096;
  localparam int unsigned HeticPrioWidth   = 8;

  localparam int unsigned HeticIpBit   = 0;
  localparam int unsigned HeticIeBit   = 1;
  localparam int unsigned HeticEdgeBit = 2;
  localparam int unsigned HeticPrioLsb = 8;

  // One interrupt line as seen through its register word; 'edge' is a
  // keyword, hence edge_trig.
  typedef struct packed {
    logic [HeticPrioWidth-1:0] prio;
    logic                      edge_trig;
    logic                      ie;
    logic                      ip;
  } hetic_line_t;

  typedef enum logic [1:0] {
    HsIdle,
    HsReq,
    HsBubble
  } hetic_hs_e;

  // Place a line's fields at their register bit positions; all else reads 0.
  function automatic logic [31:0] hetic_line_word(hetic_line_t line);
    logic [31:0] word;
    word                                = '0;
    word[HeticIpBit]                    = line.ip;
    word[HeticIeBit]                    = line.ie;
    word[HeticEdgeBit]                  = line.edge_trig;
    word[HeticPrioLsb +: HeticPrioWidth] = line.prio;
    return word;
  endfunction

endpackage

// File: rtl/apb_hetic_arbiter.sv
// Combinational pick of the highest-priority eligible line, lowest index on ties.
module hetic_arbiter #(
  parameter int unsigned NrIrqs    = 32,
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned IdWidth   = $clog2(NrIrqs)
) (
  input  logic [NrIrqs-1:0]                elig_i,
  input  logic [NrIrqs-1:0][PrioWidth-1:0] prio_i,
  output logic                             valid_o,
  output logic [IdWidth-1:0]               id_o,
  output logic [PrioWidth-1:0]             prio_o
);

  logic [PrioWidth-1:0] best_prio;
  logic [IdWidth-1:0]   best_id;

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < NrIrqs; i++) begin
      if (elig_i[i] && (prio_i[i] > best_prio)) begin
        best_prio = prio_i[i];
        best_id   = IdWidth'(i);
      end
    end
  end

  assign valid_o = |best_prio;
  assign id_o    = best_id;
  assign prio_o  = best_prio;

endmodule

// File: rtl/apb_hetic.sv
// APB interrupt controller for zeroHETI: per-line IP/IE/EDGE/PRIO registers,
// priority arbitration and a valid/ready claim handshake towards the core.
// Optional HETIC_SYNC_EN adds a 2-flop synchronizer on every irq source.
module apb_hetic
  import apb_hetic_pkg::*;
#(
  parameter  int unsigned NrIrqs       = 32,
  parameter  int unsigned PrioWidth    = HeticPrioWidth,
  parameter  int unsigned ApbAddrWidth = 32,
  parameter  int unsigned ApbDataWidth = 32,
  localparam int unsigned IdWidth      = $clog2(NrIrqs)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ApbAddrWidth-1:0] paddr_i,
  input  logic [ApbDataWidth-1:0] pwdata_i,
  output logic [ApbDataWidth-1:0] prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  input  logic [NrIrqs-1:0]       irq_src_i,
  output logic                    irq_valid_o,
  output logic [IdWidth-1:0]      irq_id_o,
  output logic [PrioWidth-1:0]    irq_prio_o,
  input  logic                    irq_ready_i
);

  localparam int unsigned OffWidth = $clog2(HeticWindowBytes);

  logic [NrIrqs-1:0]                ip_q, ip_d, ie_q, edge_q, elig, wr_hit;
  logic [NrIrqs-1:0][PrioWidth-1:0] prio_q;
  logic [NrIrqs-1:0]                src_s, src_q;
  logic [OffWidth-1:0]              offset;
  logic [IdWidth-1:0]               line_idx;
  logic                             addr_ok, access, wr_en, claim;
  hetic_line_t                      rd_line;
  logic                             arb_valid;
  logic [IdWidth-1:0]               arb_id, req_id_q, req_id_d;
  logic [PrioWidth-1:0]             arb_prio, req_prio_q, req_prio_d;
  hetic_hs_e                        state_q, state_d;
  logic                             unused_apb;

  assign unused_apb = ^{paddr_i, pwdata_i};

`ifdef HETIC_SYNC_EN
  logic [NrIrqs-1:0] sync_q1, sync_q2;

  // Two-flop synchronizer for asynchronous peripheral sources.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = irq_src_i;
`endif

  // Previous source sample, used for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) src_q <= '0;
    else         src_q <= src_s;
  end

  assign offset    = paddr_i[OffWidth-1:0];
  assign line_idx  = offset[2 +: IdWidth];
  assign addr_ok   = (32'(offset) < 32'(4 * NrIrqs)) && (offset[1:0] == 2'b00);
  assign access    = psel_i & penable_i;
  assign pslverr_o = access & ~addr_ok;
  assign wr_en     = access & pwrite_i & addr_ok;
  assign pready_o  = 1'b1;
  assign claim     = (state_q == HsReq) && irq_ready_i;

  // Read mux; bad offsets and an idle bus read as zero.
  always_comb begin
    rd_line           = '0;
    rd_line.ip        = ip_q[line_idx];
    rd_line.ie        = ie_q[line_idx];
    rd_line.edge_trig = edge_q[line_idx];
    rd_line.prio      = HeticPrioWidth'(prio_q[line_idx]);
    prdata_o          = (psel_i && addr_ok) ? ApbDataWidth'(hetic_line_word(rd_line)) : '0;
  end

  // Next pending state: level lines mirror the source; edge lines obey
  // hardware set > claim clear > software write.
  always_comb begin
    ip_d   = ip_q;
    wr_hit = '0;
    elig   = '0;
    for (int i = 0; i < NrIrqs; i++) begin
      wr_hit[i] = wr_en && (line_idx == IdWidth'(i));
      elig[i]   = ip_q[i] && ie_q[i] && (|prio_q[i]);
      if (!edge_q[i])                          ip_d[i] = src_s[i];
      else if (src_s[i] && !src_q[i])          ip_d[i] = 1'b1;
      else if (claim && req_id_q == IdWidth'(i)) ip_d[i] = 1'b0;
      else if (wr_hit[i])                      ip_d[i] = pwdata_i[HeticIpBit];
    end
  end

  // Line registers; configuration fields only change via APB writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ip_q   <= '0;
      ie_q   <= '0;
      edge_q <= '0;
      prio_q <= '0;
    end else begin
      ip_q <= ip_d;
      for (int i = 0; i < NrIrqs; i++) begin
        if (wr_hit[i]) begin
          ie_q[i]   <= pwdata_i[HeticIeBit];
          edge_q[i] <= pwdata_i[HeticEdgeBit];
          prio_q[i] <= pwdata_i[HeticPrioLsb +: PrioWidth];
        end
      end
    end
  end

  hetic_arbiter #(
    .NrIrqs   (NrIrqs),
    .PrioWidth(PrioWidth),
    .IdWidth  (IdWidth)
  ) i_arbiter (
    .elig_i (elig),
    .prio_i (prio_q),
    .valid_o(arb_valid),
    .id_o   (arb_id),
    .prio_o (arb_prio)
  );

  // Handshake state and the held request towards the core.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= HsIdle;
      req_id_q   <= '0;
      req_prio_q <= '0;
    end else begin
      state_q    <= state_d;
      req_id_q   <= req_id_d;
      req_prio_q <= req_prio_d;
    end
  end

  // Load on IDLE, hold without preemption in REQ, one bubble after a claim.
  always_comb begin
    state_d    = state_q;
    req_id_d   = req_id_q;
    req_prio_d = req_prio_q;
    unique case (state_q)
      HsIdle: begin
        if (arb_valid) begin
          state_d    = HsReq;
          req_id_d   = arb_id;
          req_prio_d = arb_prio;
        end
      end
      HsReq: begin
        if (irq_ready_i)          state_d = HsBubble;
        else if (!elig[req_id_q]) state_d = HsIdle;
      end
      HsBubble: state_d = HsIdle;
      default:  state_d = HsIdle;
    endcase
  end

  assign irq_valid_o = (state_q == HsReq);
  assign irq_id_o    = req_id_q;
  assign irq_prio_o  = req_prio_q;

endmodule

// File: doc/apb_hetic.md
Name: apb_hetic

Overview:
- APB-attached interrupt controller for zeroHETI.
- Sits between peripheral IRQ sources (mtimer, uart, ...) and the core's external interrupt interface.
- Per-line pending/enable/trigger/priority registers; arbitrates the highest-priority pending enabled line.
- Presents that line to the core over a valid/ready claim handshake.
- Occupies the hetic window of the address map, on APB demux port 3.

Parameters:
- NrIrqs, 32, number of interrupt lines; 2..1024.
- PrioWidth, 8, priority field width; 1..8.
- ApbAddrWidth, 32, APB address width.
- ApbDataWidth, 32, APB data width; fixed 32.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- psel_i  input  1  APB select
- penable_i  input  1  APB enable
- pwrite_i  input  1  APB write
- paddr_i  input  ApbAddrWidth  APB address; only offset bits [11:0] decoded
- pwdata_i  input  32  APB write data
- prdata_o  output  32  APB read data
- pready_o  output  1  APB ready
- pslverr_o  output  1  APB error
- irq_src_i  input  NrIrqs  raw interrupt sources, active-high
- irq_valid_o  output  1  interrupt request to core
- irq_id_o  output  $clog2(NrIrqs)  requested line index
- irq_prio_o  output  PrioWidth  requested line priority
- irq_ready_i  input  1  core claim; handshake completes when valid and ready

Behaviour:
- Reset value of all register and output state is 0: ip, ie, edge, prio, src_q, irq_valid_o, irq_id_o, irq_prio_o, prdata_o.
- Register map: line i at offset 4*i.
  - bit0 IP
  - bit1 IE
  - bit2 EDGE (0 level, 1 rising edge)
  - bits[8+PrioWidth-1:8] PRIO
  - other bits read 0, writes ignored
- APB timing: zero wait states; pready_o tied 1.
  - Write takes effect on the clock edge where psel & penable & pwrite.
  - prdata_o is combinational from the registers while psel_i is high, else 0.
- APB errors:
  - pslverr_o = psel & penable & (offset >= 4*NrIrqs or paddr[1:0] != 0).
  - Errored writes have no effect; errored reads return 0.
- Level line (EDGE=0):
  - IP follows the sampled source each cycle.
  - Software writes to IP are ignored; claim does not clear it.
- Edge line (EDGE=1):
  - IP sets on src_q rising (src now 1, previous sample 0).
  - Software write of IP=1 sets; IP=0 clears.
  - A claim of that id clears IP.
  - Priority within a cycle: hardware edge set > claim clear > software write.
- Changing EDGE does not alter IP directly; the new rule applies from the next cycle.
- Eligibility: line eligible iff IP & IE & PRIO != 0 (priority 0 = masked).
- Arbitration: highest PRIO wins; on tie, lowest index wins. Combinational result is registered.
- Latency: source rising edge → IP set on the next edge → irq_valid_o high one cycle later (2 cycles without sync).
- Handshake states: IDLE, REQ, BUBBLE.
  - IDLE: if any line is eligible, load id/prio and go to REQ with irq_valid_o=1.
  - REQ: id/prio held stable, with no preemption, until irq_ready_i.
    - On ready: apply the claim (edge clear) and go to BUBBLE with valid=0.
  - REQ: if the held line stops being eligible before the claim (IE cleared, level source dropped, SW clear), drop valid next cycle and go to IDLE. Id is not withdrawn otherwise.
  - BUBBLE: one cycle with valid=0, then IDLE; re-arbitration uses the updated IP.
- irq_ready_i while valid=0 is ignored.
- Reset mid-handshake: immediate return to IDLE, valid=0, all IP cleared.

Optional Feature:
- Macro HETIC_SYNC_EN.
- Defined: each irq_src_i bit passes through a 2-flop synchronizer (reset 0) before edge/level logic; latency +2 cycles.
- Undefined: irq_src_i sampled directly; sources must be synchronous to clk_i.

Decomposition:
- Add to zeroheti_pkg:
  - hetic_line_t (ip, ie, edge, prio) and its bit-position localparams
  - HeticWindowBytes = 4096
  - HeticPrioWidth default
- Sub-module hetic_arbiter: combinational max-priority / lowest-index tree over NrIrqs eligible lines; outputs valid, id, prio.

Test Plan:
- Register access:
  - Write 0x0000_0506 to offset 0x1C → read back IE=1, EDGE=1, PRIO=5, IP=0.
  - Write to offset 4*NrIrqs → pslverr=1, no state change.
- Edge trigger, line 7 (IE=1, EDGE=1, PRIO=3):
  - Pulse src[7] 1 cycle → valid=1, id=7, prio=3 two cycles later; held until ready.
  - After ready: IP[7]=0, valid=0 for ≥1 cycle.
- Arbitration:
  - Lines 2 and 9 at PRIO=4, line 5 at PRIO=6, all pending → id=5 claimed first, then 2, then 9.
- No preemption and masking:
  - During REQ on id=2 (prio 1), line 4 with prio 7 goes pending → id stays 2 until ready, then 4 follows after the bubble.
  - PRIO=0 line never requested.
- Level trigger:
  - src[3] held high, claimed → re-request of id=3 after the bubble.
  - Src drops while in REQ → valid drops next cycle.
- Reset and sync:
  - Assert rst_ni during REQ → all outputs 0 asynchronously.
  - With HETIC_SYNC_EN, pending-to-valid latency = 4 cycles.
